at_response_monitor: RTL and testbench

// - Consumes the HC-05 UART receive byte stream (rx_data/rx_data_valid from UART_rx) during AT mode.
// - Classifies the module's reply and reports a done/status result to the connection FSM.
// - Its at_done output drives the FSM's did_at_finish exit from Receive_AT_Response.
// - Also exposes the last two received bytes and a byte count on Opal Kelly wire-outs for debug.

---
 rtl/at_response_monitor_pkg.sv | 33 +++
 rtl/at_response_monitor_if.sv | 32 +++
 rtl/at_response_monitor_line_classifier.sv | 70 +++++++
 rtl/at_response_monitor.sv | 164 ++++++++++++++++
 tb/tb_at_response_monitor.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/at_response_monitor_pkg.sv
// -----------------------------------------------------------------------------
// at_response_monitor_pkg
// Shared definitions for the HC-05 AT response monitor:
//   - ASCII constants used to recognise line terminators and "OK"/"ERROR"
//   - FSM state encoding (also exported on the debug state output)
//   - error_char(): expected character at each position of "ERROR"
// -----------------------------------------------------------------------------
package at_response_monitor_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_R  = 8'h52;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LISTEN = 2'b01,
    ST_GOT_CR = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // Character expected at position idx (0..4) of "ERROR".
  function automatic logic [7:0] error_char(input logic [2:0] idx);
    case (idx)
      3'd0:    error_char = ASCII_E;
      3'd3:    error_char = ASCII_O;
      default: error_char = ASCII_R;
    endcase
  endfunction

endpackage

// File: rtl/at_response_monitor_if.sv
// -----------------------------------------------------------------------------
// at_response_monitor_if
// Bundles the control, UART receive and result/debug signals of the monitor.
//   master : connection FSM / host side (drives arm, clear, rx byte stream)
//   slave  : the monitor itself (drives done/status and debug wire-outs)
// -----------------------------------------------------------------------------
interface at_response_monitor_if;
  logic       arm;
  logic       clear;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       at_done;
  logic       at_ok;
  logic       at_error;
  logic       at_timeout;
  logic [7:0] byte_count;
  logic [7:0] last_byte;
  logic [7:0] prev_byte;
  logic [1:0] state;

  modport master (
    output arm, clear, rx_data, rx_data_valid,
    input  at_done, at_ok, at_error, at_timeout,
    input  byte_count, last_byte, prev_byte, state
  );

  modport slave (
    input  arm, clear, rx_data, rx_data_valid,
    output at_done, at_ok, at_error, at_timeout,
    output byte_count, last_byte, prev_byte, state
  );
endinterface

// File: rtl/at_response_monitor_line_classifier.sv
// -----------------------------------------------------------------------------
// at_line_classifier
// Tracks the characters of the current reply line and reports whether the
// line so far is exactly "OK" or begins with "ERROR".
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   line_clr      : start a new line (clears length and match flags)
//   char_valid    : char is a line character (terminators are filtered out
//                   by the caller)
//   char          : the character
//   is_ok         : line is exactly "OK"
//   is_error      : line's first five characters are "ERROR"
// A line whose length reached MAX_LINE is treated as an info line and never
// matches.
// -----------------------------------------------------------------------------
module at_line_classifier
  import at_response_monitor_pkg::*;
#(
  parameter logic [7:0] MAX_LINE = 8'd32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       line_clr,
  input  logic       char_valid,
  input  logic [7:0] char,
  output logic       is_ok,
  output logic       is_error
);

  logic [7:0] line_len_reg;
  logic       ok_match_reg;
  logic       err_match_reg;
  logic       saturated;

  assign saturated = (line_len_reg == MAX_LINE);

  // Match flags are rewritten from the first character of every line, so
  // their cleared value never leaks into a classification.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_len_reg  <= 8'd0;
      ok_match_reg  <= 1'b0;
      err_match_reg <= 1'b0;
    end else if (line_clr) begin
      line_len_reg  <= 8'd0;
      ok_match_reg  <= 1'b0;
      err_match_reg <= 1'b0;
    end else if (char_valid) begin
      if (!saturated)
        line_len_reg <= line_len_reg + 8'd1;

      if (line_len_reg == 8'd0)
        ok_match_reg <= (char == ASCII_O);
      else if (line_len_reg == 8'd1)
        ok_match_reg <= ok_match_reg && (char == ASCII_K);
      else
        ok_match_reg <= 1'b0;

      // Past the fifth character the ERROR verdict is frozen.
      if (line_len_reg == 8'd0)
        err_match_reg <= (char == ASCII_E);
      else if (line_len_reg < 8'd5)
        err_match_reg <= err_match_reg && (char == error_char(line_len_reg[2:0]));
    end
  end

  assign is_ok    = !saturated && ok_match_reg && (line_len_reg == 8'd2);
  assign is_error = !saturated && err_match_reg && (line_len_reg >= 8'd5);

endmodule

// File: rtl/at_response_monitor.sv
// -----------------------------------------------------------------------------
// at_response_monitor
// Watches the HC-05 UART receive stream while in AT mode and classifies the
// module's reply: a line "OK", a line starting "ERROR", or rx silence of
// TIMEOUT_CYCLES clocks. at_done feeds the connection FSM; the byte capture
// registers are debug wire-outs.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : arm/clear pulses, rx_data/rx_data_valid byte stream,
//                  at_done/at_ok/at_error/at_timeout result levels,
//                  byte_count/last_byte/prev_byte/state debug outputs
// -----------------------------------------------------------------------------
module at_response_monitor
  import at_response_monitor_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [7:0]  MAX_LINE       = 8'd32
) (
  input logic             clock,
  input logic             reset,
  at_response_monitor_if.slave bus
);

  state_t      state_reg, state_next;
  logic        ok_reg, ok_next;
  logic        err_reg, err_next;
  logic        to_reg, to_next;
  logic [23:0] timer_reg;
  logic [7:0]  count_reg;
  logic [7:0]  last_reg;
  logic [7:0]  prev_reg;

  logic listening;
  logic accept;
  logic is_cr;
  logic is_lf;
  logic line_end;
  logic char_valid;
  logic line_clr;
  logic timer_hit;
  logic line_is_ok;
  logic line_is_error;

  assign listening = (state_reg == ST_LISTEN) || (state_reg == ST_GOT_CR);
  // arm/clear discard any byte arriving in the same cycle.
  assign accept    = bus.rx_data_valid && listening && !bus.arm && !bus.clear;
  assign is_cr     = (bus.rx_data == ASCII_CR);
  assign is_lf     = (bus.rx_data == ASCII_LF);
  assign line_end  = accept && (state_reg == ST_GOT_CR) && is_lf;
  // CRs and the terminating LF are not line characters; a lone LF is.
  assign char_valid = accept && !is_cr && !line_end;
  assign line_clr   = bus.arm || bus.clear || line_end;
  assign timer_hit  = (timer_reg == TIMEOUT_CYCLES - 24'd1);

  at_line_classifier #(
    .MAX_LINE (MAX_LINE)
  ) u_classifier (
    .clock      (clock),
    .reset      (reset),
    .line_clr   (line_clr),
    .char_valid (char_valid),
    .char       (bus.rx_data),
    .is_ok      (line_is_ok),
    .is_error   (line_is_error)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ok_reg    <= 1'b0;
      err_reg   <= 1'b0;
      to_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ok_reg    <= ok_next;
      err_reg   <= err_next;
      to_reg    <= to_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ok_next    = ok_reg;
    err_next   = err_reg;
    to_next    = to_reg;
    if (bus.clear) begin
      state_next = ST_IDLE;
      ok_next    = 1'b0;
      err_next   = 1'b0;
      to_next    = 1'b0;
    end else if (bus.arm) begin
      state_next = ST_LISTEN;
      ok_next    = 1'b0;
      err_next   = 1'b0;
      to_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_LISTEN, ST_GOT_CR: begin
          // A received byte takes precedence over an expiring timer.
          if (accept) begin
            if (line_end) begin
              if (line_is_ok) begin
                state_next = ST_DONE;
                ok_next    = 1'b1;
              end else if (line_is_error) begin
                state_next = ST_DONE;
                err_next   = 1'b1;
              end else begin
                state_next = ST_LISTEN;
              end
            end else if (is_cr && (state_reg == ST_LISTEN)) begin
              state_next = ST_GOT_CR;
            end else begin
              state_next = ST_LISTEN;
            end
          end else if (timer_hit) begin
            state_next = ST_DONE;
            to_next    = 1'b1;
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_reg <= 24'd0;
    end else if (bus.arm || bus.clear || accept) begin
      timer_reg <= 24'd0;
    end else if (listening) begin
      timer_reg <= timer_reg + 24'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= 8'd0;
      last_reg  <= 8'd0;
      prev_reg  <= 8'd0;
    end else if (bus.arm || bus.clear) begin
      count_reg <= 8'd0;
      last_reg  <= 8'd0;
      prev_reg  <= 8'd0;
    end else if (accept) begin
      if (count_reg != 8'hFF)
        count_reg <= count_reg + 8'd1;
      last_reg <= bus.rx_data;
      prev_reg <= last_reg;
    end
  end

  assign bus.at_done    = (state_reg == ST_DONE);
  assign bus.at_ok      = ok_reg;
  assign bus.at_error   = err_reg;
  assign bus.at_timeout = to_reg;
  assign bus.byte_count = count_reg;
  assign bus.last_byte  = last_reg;
  assign bus.prev_byte  = prev_reg;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_at_response_monitor.sv
module tb_at_response_monitor;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  at_response_monitor_if bus ();

  at_response_monitor #(
    .TIMEOUT_CYCLES (24'd100),
    .MAX_LINE       (8'd32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [191:0] msg;
    int           n;
    logic [1:0]   st;
    logic         done;
    logic         ok;
    logic         err;
    logic [7:0]   cnt;
    logic [7:0]   prev;
    logic [7:0]   last;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [191:0] m, input int n, input logic [1:0] st,
                              input logic done, input logic ok, input logic err,
                              input logic [7:0] cnt, input logic [7:0] prev, input logic [7:0] last);
    vec_t v;
    v.msg = m; v.n = n; v.st = st; v.done = done; v.ok = ok; v.err = err;
    v.cnt = cnt; v.prev = prev; v.last = last;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic done, input logic ok,
                              input logic err, input logic to);
    check({tag, " done"},    {31'd0, bus.at_done},    {31'd0, done});
    check({tag, " ok"},      {31'd0, bus.at_ok},      {31'd0, ok});
    check({tag, " error"},   {31'd0, bus.at_error},   {31'd0, err});
    check({tag, " timeout"}, {31'd0, bus.at_timeout}, {31'd0, to});
  endtask

  task automatic check_capture(input string tag, input logic [1:0] st, input logic [7:0] cnt,
                               input logic [7:0] prev, input logic [7:0] last);
    check({tag, " state"}, {30'd0, bus.state},      {30'd0, st});
    check({tag, " count"}, {24'd0, bus.byte_count}, {24'd0, cnt});
    check({tag, " prev"},  {24'd0, bus.prev_byte},  {24'd0, prev});
    check({tag, " last"},  {24'd0, bus.last_byte},  {24'd0, last});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.arm = 1'b0; bus.clear = 1'b0; bus.rx_data = 8'h00; bus.rx_data_valid = 1'b0;

    vecs[0] = mk("OK\r\n",                 4, 2'd3, 1, 1, 0, 8'd4,  8'h0D, 8'h0A);
    vecs[1] = mk("+NAME:HC05\r\nOK\r\n",  16, 2'd3, 1, 1, 0, 8'd16, 8'h0D, 8'h0A);
    vecs[2] = mk("ERROR:(0)\r\n",         11, 2'd3, 1, 0, 1, 8'd11, 8'h0D, 8'h0A);
    vecs[3] = mk("+NAME:HC05\r\n",        12, 2'd1, 0, 0, 0, 8'd12, 8'h0D, 8'h0A);
    vecs[4] = mk("OKX\r\n",                5, 2'd1, 0, 0, 0, 8'd5,  8'h0D, 8'h0A);
    vecs[5] = mk("ERRO\r\n",               6, 2'd1, 0, 0, 0, 8'd6,  8'h0D, 8'h0A);
    vecs[6] = mk("O\nK\r\n",               5, 2'd1, 0, 0, 0, 8'd5,  8'h0D, 8'h0A);
    vecs[7] = mk("ERROR\r\n",              7, 2'd3, 1, 0, 1, 8'd7,  8'h0D, 8'h0A);
    vecs[8] = mk("OK\r",                   3, 2'd2, 0, 0, 0, 8'd3,  8'h4B, 8'h0D);
    vecs[9] = mk("AT\r\nOK\r\n",           8, 2'd3, 1, 1, 0, 8'd8,  8'h0D, 8'h0A);

    // Reset state
    tick(); tick();
    check_status("reset", 0, 0, 0, 0);
    check_capture("reset", 2'd0, 8'd0, 8'd0, 8'd0);
    reset = 1'b0;
    tick();

    // Table-driven line classification
    for (int v = 0; v < 10; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      pulse_arm();
      for (int i = 0; i < vecs[v].n; i++) begin
        logic [7:0] b;
        if (i == vecs[v].n - 1)
          check({tag, " done before last byte"}, {31'd0, bus.at_done}, 32'd0);
        b = vecs[v].msg[8*(vecs[v].n-1-i) +: 8];
        send_byte(b);
      end
      check_status(tag, vecs[v].done, vecs[v].ok, vecs[v].err, 1'b0);
      check_capture(tag, vecs[v].st, vecs[v].cnt, vecs[v].prev, vecs[v].last);
    end

    // Timeout from arm: done appears 100 edges after the arm edge
    pulse_arm();
    for (int i = 1; i < 100; i++) tick();
    check_status("timeout pre", 0, 0, 0, 0);
    tick();
    check_status("timeout", 1, 0, 0, 1);

    // A byte 50 cycles in restarts the count
    pulse_arm();
    for (int i = 1; i < 50; i++) tick();
    send_byte(8'h41);
    for (int i = 51; i < 150; i++) tick();
    check_status("restart pre", 0, 0, 0, 0);
    tick();
    check_status("restart", 1, 0, 0, 1);
    check_capture("restart", 2'd3, 8'd1, 8'd0, 8'h41);

    // Bytes while DONE are ignored
    send_byte(8'h5A);
    check_capture("done ignore", 2'd3, 8'd1, 8'd0, 8'h41);

    // clear returns to IDLE and drops everything; IDLE ignores bytes
    pulse_clear();
    check_status("clear", 0, 0, 0, 0);
    check_capture("clear", 2'd0, 8'd0, 8'd0, 8'd0);
    send_byte(8'h51);
    check_capture("idle ignore", 2'd0, 8'd0, 8'd0, 8'd0);

    // arm with a byte in the same cycle: byte discarded
    bus.arm = 1'b1; bus.rx_data = 8'h41; bus.rx_data_valid = 1'b1;
    tick();
    bus.arm = 1'b0; bus.rx_data_valid = 1'b0;
    check_capture("arm+valid", 2'd1, 8'd0, 8'd0, 8'd0);

    // arm and clear together: clear wins
    bus.arm = 1'b1; bus.clear = 1'b1;
    tick();
    bus.arm = 1'b0; bus.clear = 1'b0;
    check_capture("arm+clear", 2'd0, 8'd0, 8'd0, 8'd0);

    // LF arriving exactly when the timer would expire: the line end wins
    pulse_arm();
    send_byte(8'h4F); send_byte(8'h4B); send_byte(8'h0D);
    for (int i = 1; i < 100; i++) tick();
    check_capture("lf vs timeout pre", 2'd2, 8'd3, 8'h4B, 8'h0D);
    send_byte(8'h0A);
    check_status("lf vs timeout", 1, 1, 0, 0);

    // Asynchronous reset mid-line, then the tail of the line alone is not OK
    pulse_arm();
    send_byte(8'h4F);
    reset = 1'b1;
    #2;
    check_status("async reset", 0, 0, 0, 0);
    check_capture("async reset", 2'd0, 8'd0, 8'd0, 8'd0);
    tick();
    reset = 1'b0;
    pulse_arm();
    send_byte(8'h4B); send_byte(8'h0D); send_byte(8'h0A);
    check_status("after reset K", 0, 0, 0, 0);
    check_capture("after reset K", 2'd1, 8'd3, 8'h0D, 8'h0A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
